// File: rtl/pingpong_combine_scheduler_pkg.sv
// Shared constants for the ping-pong combine scheduler.
//   NUM_USERS / UIDX_W : default user count and user index width
//   NONE_USER          : user index driven when no combine is granted
//   state_e            : one-hot scheduler FSM encoding
package pingpong_combine_scheduler_pkg;
  localparam int NUM_USERS = 8;
  localparam int UIDX_W    = 4;
  localparam logic [UIDX_W-1:0] NONE_USER = 4'hf;

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_SCAN = 5'b00010,
    ST_REQ  = 5'b00100,
    ST_BUSY = 5'b01000,
    ST_DONE = 5'b10000
  } state_e;
endpackage

// File: rtl/pingpong_combine_scheduler_if.sv
// Writer + combine-engine bus of the ping-pong combine scheduler.
//   slave  : scheduler side (takes slot start, write done, ack/done;
//            drives write bank/full, combine request, overflow)
//   master : environment side (writers and combine engine)
interface pingpong_combine_scheduler_if #(
  parameter int NUM_USERS = pingpong_combine_scheduler_pkg::NUM_USERS,
  parameter int UIDX_W    = pingpong_combine_scheduler_pkg::UIDX_W
);
  logic                 i_slot_start;
  logic                 i_wr_done;
  logic [UIDX_W-1:0]    i_wr_user;
  logic [NUM_USERS-1:0] o_wr_bank;
  logic [NUM_USERS-1:0] o_wr_full;
  logic                 o_comb_req;
  logic [UIDX_W-1:0]    o_comb_user;
  logic                 o_comb_bank;
  logic                 i_comb_ack;
  logic                 i_comb_done;
  logic                 o_ovf;

  modport slave (
    input  i_slot_start, i_wr_done, i_wr_user, i_comb_ack, i_comb_done,
    output o_wr_bank, o_wr_full, o_comb_req, o_comb_user, o_comb_bank, o_ovf
  );

  modport master (
    output i_slot_start, i_wr_done, i_wr_user, i_comb_ack, i_comb_done,
    input  o_wr_bank, o_wr_full, o_comb_req, o_comb_user, o_comb_bank, o_ovf
  );
endinterface

// File: rtl/pingpong_combine_scheduler_bank_tracker.sv
// Per-user ping-pong bank state: two full flags, write and read pointers.
//   i_core_clk / i_rx_rst : clock, synchronous active-high reset
//   wr_evt     : writer completed the current write bank
//   rd_release : combine of the current read bank finished
//   wr_bank    : bank the writer fills next
//   rd_bank    : bank the combine engine reads next
//   rd_full    : current read bank holds data
//   both_full  : no free bank left for the writer
//   ovf_evt    : wr_evt arrived while the write bank was still full
module pp_bank_tracker (
  input  logic i_core_clk,
  input  logic i_rx_rst,
  input  logic wr_evt,
  input  logic rd_release,
  output logic wr_bank,
  output logic rd_bank,
  output logic rd_full,
  output logic both_full,
  output logic ovf_evt
);
  logic [1:0] full_q, full_d;
  logic       wr_ptr_q, rd_ptr_q;
  logic       wr_ok;

  // Overflow is judged on the registered flags, so a write racing the
  // release of that same bank still counts as overflow.
  assign ovf_evt = wr_evt & full_q[wr_ptr_q];
  assign wr_ok   = wr_evt & ~full_q[wr_ptr_q];

  always_comb begin
    full_d = full_q;
    if (rd_release) full_d[rd_ptr_q] = 1'b0;
    if (wr_ok)      full_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      full_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      full_q <= full_d;
      if (wr_ok)      wr_ptr_q <= ~wr_ptr_q;
      if (rd_release) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign wr_bank   = wr_ptr_q;
  assign rd_bank   = rd_ptr_q;
  assign rd_full   = full_q[rd_ptr_q];
  assign both_full = &full_q;
endmodule

// File: rtl/pingpong_combine_scheduler.sv
// Ping-pong bank owner and round-robin combine scheduler.
//   i_core_clk : core clock (rising edge)
//   i_rx_rst   : synchronous active-high reset
//   bus        : writer done/user in, write bank/full out, combine
//                req/user/bank out, ack/done in, sticky overflow out
module pingpong_combine_scheduler #(
  parameter int NUM_USERS = pingpong_combine_scheduler_pkg::NUM_USERS,
  parameter int UIDX_W    = pingpong_combine_scheduler_pkg::UIDX_W
) (
  input  logic                        i_core_clk,
  input  logic                        i_rx_rst,
  pingpong_combine_scheduler_if.slave bus
);
  import pingpong_combine_scheduler_pkg::*;

  state_e               state_q, state_d;
  logic [UIDX_W-1:0]    p_q, p_d, p_inc;
  logic                 ovf_q;
  logic                 granted;
  logic                 sel_full, sel_bank;
  logic [NUM_USERS-1:0] wr_evt, rd_release, wr_bank, rd_bank;
  logic [NUM_USERS-1:0] rd_full, both_full, ovf_evt;

  // Out-of-range user indices never match a tracker, so they are dropped.
  for (genvar g = 0; g < NUM_USERS; g++) begin : g_user
    assign wr_evt[g]     = bus.i_wr_done && (bus.i_wr_user == UIDX_W'(g));
    assign rd_release[g] = (state_q == ST_DONE) && (p_q == UIDX_W'(g));

    pp_bank_tracker u_trk (
      .i_core_clk (i_core_clk),
      .i_rx_rst   (i_rx_rst),
      .wr_evt     (wr_evt[g]),
      .rd_release (rd_release[g]),
      .wr_bank    (wr_bank[g]),
      .rd_bank    (rd_bank[g]),
      .rd_full    (rd_full[g]),
      .both_full  (both_full[g]),
      .ovf_evt    (ovf_evt[g])
    );
  end

  // Read-side view of the user under the scan pointer.
  always_comb begin
    sel_full = 1'b0;
    sel_bank = 1'b0;
    for (int u = 0; u < NUM_USERS; u++) begin
      if (p_q == UIDX_W'(u)) begin
        sel_full = rd_full[u];
        sel_bank = rd_bank[u];
      end
    end
  end

  assign p_inc = (p_q == UIDX_W'(NUM_USERS - 1)) ? '0 : p_q + 1'b1;

  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      ovf_q   <= ovf_q | (|ovf_evt);
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    case (state_q)
      ST_IDLE: if (bus.i_slot_start) state_d = ST_SCAN;
      ST_SCAN: begin
        if (sel_full) state_d = ST_REQ;
        else          p_d     = p_inc;
      end
      ST_REQ:  if (bus.i_comb_ack)  state_d = ST_BUSY;
      // Only sampled in BUSY, so a done coincident with ack is dropped.
      ST_BUSY: if (bus.i_comb_done) state_d = ST_DONE;
      ST_DONE: begin
        // Moving past the served user keeps the rotation fair.
        p_d     = p_inc;
        state_d = ST_SCAN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign granted         = (state_q == ST_REQ) || (state_q == ST_BUSY);
  assign bus.o_comb_req  = (state_q == ST_REQ);
  assign bus.o_comb_user = granted ? p_q : UIDX_W'(NONE_USER);
  assign bus.o_comb_bank = granted & sel_bank;
  assign bus.o_wr_bank   = wr_bank;
  assign bus.o_wr_full   = both_full;
  assign bus.o_ovf       = ovf_q;
endmodule

// File: tb/tb_pingpong_combine_scheduler.sv
module tb_pingpong_combine_scheduler;
  import pingpong_combine_scheduler_pkg::*;

  localparam int NU = NUM_USERS;
  localparam int M_IDLE = 0, M_SCAN = 1, M_REQ = 2, M_BUSY = 3, M_DONE = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pingpong_combine_scheduler_if #(.NUM_USERS(NU), .UIDX_W(UIDX_W)) bus ();

  pingpong_combine_scheduler #(.NUM_USERS(NU), .UIDX_W(UIDX_W)) dut (
    .i_core_clk (clk),
    .i_rx_rst   (rst),
    .bus        (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: each user owns a FIFO of filled bank ids (max two);
  // the front is the bank the combine engine must read.
  bit fq [NU][$];
  bit mwb [NU];
  bit movf;
  int mst;
  int mp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int os, op;
    if (rst) begin
      for (int u = 0; u < NU; u++) begin
        fq[u].delete();
        mwb[u] = 1'b0;
      end
      movf = 1'b0;
      mst  = M_IDLE;
      mp   = 0;
      return;
    end
    os = mst;
    op = mp;
    case (os)
      M_IDLE: if (bus.i_slot_start) mst = M_SCAN;
      M_SCAN: if (fq[op].size() != 0) mst = M_REQ; else mp = (op + 1) % NU;
      M_REQ:  if (bus.i_comb_ack) mst = M_BUSY;
      M_BUSY: if (bus.i_comb_done) mst = M_DONE;
      M_DONE: begin mp = (op + 1) % NU; mst = M_SCAN; end
      default: mst = M_IDLE;
    endcase
    if (bus.i_wr_done && int'(bus.i_wr_user) < NU) begin
      int w;
      w = int'(bus.i_wr_user);
      if (fq[w].size() == 2) movf = 1'b1;
      else begin
        fq[w].push_back(mwb[w]);
        mwb[w] = ~mwb[w];
      end
    end
    if (os == M_DONE && fq[op].size() != 0) void'(fq[op].pop_front());
  endtask

  task automatic check_all();
    logic [NU-1:0] ewb, ewf;
    int eu, eb;
    bit g;
    for (int u = 0; u < NU; u++) begin
      ewb[u] = mwb[u];
      ewf[u] = (fq[u].size() == 2);
    end
    g  = (mst == M_REQ) || (mst == M_BUSY);
    eu = g ? mp : 15;
    eb = (g && fq[mp].size() != 0) ? int'(fq[mp][0]) : 0;
    chk("wr_bank",   32'(bus.o_wr_bank),   32'(ewb));
    chk("wr_full",   32'(bus.o_wr_full),   32'(ewf));
    chk("comb_req",  32'(bus.o_comb_req),  32'(mst == M_REQ));
    chk("comb_user", 32'(bus.o_comb_user), eu);
    chk("comb_bank", 32'(bus.o_comb_bank), eb);
    chk("ovf",       32'(bus.o_ovf),       32'(movf));
  endtask

  // One clock: model follows the sampled inputs, pulses drop, outputs checked.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    bus.i_slot_start = 1'b0;
    bus.i_wr_done    = 1'b0;
    bus.i_comb_ack   = 1'b0;
    bus.i_comb_done  = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wr(input int u);
    bus.i_wr_done = 1'b1;
    bus.i_wr_user = 4'(u);
  endtask

  task automatic wait_req(input int max_cyc, input string tag);
    int n = 0;
    while (bus.o_comb_req !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    chk({tag, "_req_seen"}, 32'(bus.o_comb_req), 32'd1);
  endtask

  task automatic serve(input int eu, input int eb, input string tag);
    wait_req(40, tag);
    chk({tag, "_user"}, 32'(bus.o_comb_user), eu);
    chk({tag, "_bank"}, 32'(bus.o_comb_bank), eb);
    bus.i_comb_ack = 1'b1;
    tick();
    tick();
    bus.i_comb_done = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.i_slot_start = 1'b0;
    bus.i_wr_done    = 1'b0;
    bus.i_wr_user    = '0;
    bus.i_comb_ack   = 1'b0;
    bus.i_comb_done  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_user", 32'(bus.o_comb_user), 32'hf);
    chk("rst_req",  32'(bus.o_comb_req),  32'd0);

    // 1: start + write user 0 together; request two edges later.
    bus.i_slot_start = 1'b1;
    wr(0);
    tick();
    chk("t1_wrbank0", 32'(bus.o_wr_bank[0]), 32'd1);
    chk("t1_noreq",   32'(bus.o_comb_req),   32'd0);
    tick();
    chk("t1_req",  32'(bus.o_comb_req),  32'd1);
    chk("t1_user", 32'(bus.o_comb_user), 32'd0);
    chk("t1_bank", 32'(bus.o_comb_bank), 32'd0);
    bus.i_comb_ack = 1'b1;
    tick();
    chk("t1_busy_req", 32'(bus.o_comb_req), 32'd0);
    bus.i_comb_done = 1'b1;
    tick();
    chk("t1_done_user", 32'(bus.o_comb_user), 32'hf);
    wr(1);
    tick();
    tick();
    chk("t1_next_req",  32'(bus.o_comb_req),  32'd1);
    chk("t1_next_user", 32'(bus.o_comb_user), 32'd1);
    serve(1, 0, "t1b");

    // 2: banks filled for 2, 5, 7 before start.
    do_reset();
    wr(2); tick();
    wr(5); tick();
    wr(7); tick();
    bus.i_slot_start = 1'b1;
    tick();
    serve(2, 0, "t2a");
    serve(5, 0, "t2b");
    serve(7, 0, "t2c");
    chk("t2_empty", 32'(bus.o_wr_full), 32'd0);

    // 3: overflow on user 3 while idle.
    do_reset();
    wr(3); tick();
    wr(3); tick();
    chk("t3_full", 32'(bus.o_wr_full[3]), 32'd1);
    wr(3); tick();
    chk("t3_ovf",  32'(bus.o_ovf),        32'd1);
    chk("t3_bank", 32'(bus.o_wr_bank[3]), 32'd0);

    // 4: ack held off 10 cycles; stray done in REQ ignored.
    do_reset();
    wr(6);
    bus.i_slot_start = 1'b1;
    tick();
    wait_req(20, "t4");
    for (int i = 0; i < 10; i++) begin
      if (i == 3) bus.i_comb_done = 1'b1;
      tick();
      chk("t4_req_hold",  32'(bus.o_comb_req),  32'd1);
      chk("t4_user_hold", 32'(bus.o_comb_user), 32'd6);
      chk("t4_bank_hold", 32'(bus.o_comb_bank), 32'd0);
    end
    bus.i_comb_ack = 1'b1;
    tick();
    bus.i_comb_done = 1'b1;
    tick();
    tick();

    // 5: write to the bank being released in DONE.
    do_reset();
    wr(4); tick();
    wr(4); tick();
    bus.i_slot_start = 1'b1;
    tick();
    wait_req(20, "t5");
    chk("t5_user", 32'(bus.o_comb_user), 32'd4);
    bus.i_comb_ack = 1'b1;
    tick();
    bus.i_comb_done = 1'b1;
    tick();
    wr(4);
    tick();
    chk("t5_ovf",   32'(bus.o_ovf),        32'd1);
    chk("t5_full",  32'(bus.o_wr_full[4]), 32'd0);
    chk("t5_wrbnk", 32'(bus.o_wr_bank[4]), 32'd0);
    serve(4, 1, "t5b");

    // 6: reset during BUSY.
    do_reset();
    wr(1);
    bus.i_slot_start = 1'b1;
    tick();
    wait_req(20, "t6");
    bus.i_comb_ack = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_user", 32'(bus.o_comb_user), 32'hf);
    chk("t6_full", 32'(bus.o_wr_full),   32'd0);
    chk("t6_bank", 32'(bus.o_wr_bank),   32'd0);
    wr(2);
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_noreq", 32'(bus.o_comb_req), 32'd0);
    end
    bus.i_slot_start = 1'b1;
    tick();
    serve(2, 0, "t6b");

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      bus.i_slot_start = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 2) == 0) wr(int'($urandom_range(0, 15)));
      bus.i_comb_ack  = (bus.o_comb_req && $urandom_range(0, 2) == 0) ||
                        ($urandom_range(0, 9) == 0);
      bus.i_comb_done = (!bus.o_comb_req && bus.o_comb_user != 4'hf &&
                         $urandom_range(0, 3) == 0) || ($urandom_range(0, 9) == 0);
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
